// File: rtl/score_disp_pkg.sv
// Shared constants, FSM state type and the double-dabble step for the score display.
package score_disp_pkg;

  localparam int unsigned SCORE_W      = 7;
  localparam int unsigned BCD_W        = 4;
  localparam int unsigned BCD_DIGITS   = 3;
  localparam int unsigned DD_W         = SCORE_W + BCD_W * BCD_DIGITS;
  localparam int unsigned SEG_W        = 8;
  localparam int unsigned SHIFT_CYCLES = 7;
  localparam int unsigned SHIFT_CNT_W  = 3;

  // Segment patterns, bit order {dp,g,f,e,d,c,b,a}, active-high
  localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;
  localparam logic [SEG_W-1:0] SEG_DP    = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift left by one.
  // Layout is {hundreds, tens, units, binary}.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] t;
    t = v;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      if (t[SCORE_W + BCD_W * d +: BCD_W] >= 4'd5)
        t[SCORE_W + BCD_W * d +: BCD_W] = t[SCORE_W + BCD_W * d +: BCD_W] + 4'd3;
    end
    return t << 1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment pattern; non-decimal codes show blank.
module seg7_decode
  import score_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  // Digit lookup
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_seg_encoder.sv
// Converts two binary scores to four seven-segment bytes via a serial double dabble,
// with per-player blinking driven by a free-running half-period counter.
module score_seg_encoder
  import score_disp_pkg::*;
#(
  parameter int unsigned BLINK_INTERVAL = 25_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score_a,
  input  logic [SCORE_W-1:0] score_b,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic               blink_a,
  input  logic               blink_b,
  output logic [31:0]        leds
);

  localparam int unsigned BLINK_CNT_W = (BLINK_INTERVAL > 1) ? $clog2(BLINK_INTERVAL) : 1;

  state_t                  state_q, state_d;
  logic [SHIFT_CNT_W-1:0]  shift_cnt_q;
  logic [DD_W-1:0]         dd_a_q, dd_b_q;
  logic [31:0]             seg_q, seg_d;
  logic [BLINK_CNT_W-1:0]  blink_cnt_q;
  logic                    phase_q;
  logic                    accept;
  logic [SEG_W-1:0]        dec_a_tens, dec_a_units, dec_b_tens, dec_b_units;
  logic                    over_a, over_b;
  logic [SEG_W-1:0]        a_tens_byte, a_units_byte, b_tens_byte, b_units_byte;
  logic                    hide_a, hide_b;

  assign upd_ready = (state_q == IDLE);
  assign accept    = upd_valid && upd_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (upd_valid) state_d = SHIFT;
      SHIFT:   if (shift_cnt_q == SHIFT_CNT_W'(SHIFT_CYCLES - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture scores on accept, then iterate double dabble on both players in parallel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dd_a_q      <= '0;
      dd_b_q      <= '0;
      shift_cnt_q <= '0;
    end else if (accept) begin
      dd_a_q      <= DD_W'(score_a);
      dd_b_q      <= DD_W'(score_b);
      shift_cnt_q <= '0;
    end else if (state_q == SHIFT) begin
      dd_a_q      <= dd_step(dd_a_q);
      dd_b_q      <= dd_step(dd_b_q);
      shift_cnt_q <= shift_cnt_q + SHIFT_CNT_W'(1);
    end
  end

  seg7_decode u_dec_a_tens  (.bcd(dd_a_q[SCORE_W + BCD_W +: BCD_W]), .seg(dec_a_tens));
  seg7_decode u_dec_a_units (.bcd(dd_a_q[SCORE_W +: BCD_W]),         .seg(dec_a_units));
  seg7_decode u_dec_b_tens  (.bcd(dd_b_q[SCORE_W + BCD_W +: BCD_W]), .seg(dec_b_tens));
  seg7_decode u_dec_b_units (.bcd(dd_b_q[SCORE_W +: BCD_W]),         .seg(dec_b_units));

  // Display formatting: dash above 99, blank leading zero, separator dp on A units
  always_comb begin
    over_a       = (dd_a_q[SCORE_W + 2 * BCD_W +: BCD_W] != '0);
    over_b       = (dd_b_q[SCORE_W + 2 * BCD_W +: BCD_W] != '0);
    a_tens_byte  = over_a ? SEG_DASH
                 : ((dd_a_q[SCORE_W + BCD_W +: BCD_W] == '0) ? SEG_BLANK : dec_a_tens);
    a_units_byte = (over_a ? SEG_DASH : dec_a_units) | SEG_DP;
    b_tens_byte  = over_b ? SEG_DASH
                 : ((dd_b_q[SCORE_W + BCD_W +: BCD_W] == '0) ? SEG_BLANK : dec_b_tens);
    b_units_byte = over_b ? SEG_DASH : dec_b_units;
    seg_d        = {b_units_byte, b_tens_byte, a_units_byte, a_tens_byte};
  end

  // Segment register, written only in COMMIT
  always_ff @(posedge clk) begin
    if (!rst_n)                 seg_q <= '0;
    else if (state_q == COMMIT) seg_q <= seg_d;
  end

  // Free-running blink half-period counter and phase (0 = visible)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == BLINK_CNT_W'(BLINK_INTERVAL - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_CNT_W'(1);
    end
  end

  assign hide_a = blink_a && phase_q;
  assign hide_b = blink_b && phase_q;
  assign leds   = {hide_b ? 16'h0000 : seg_q[31:16], hide_a ? 16'h0000 : seg_q[15:0]};

endmodule

// File: tb/tb_score_seg_encoder.sv
// Bench for score_seg_encoder: vector table, randomized updates, blink and handshake corners.
module tb_score_seg_encoder;

  localparam int unsigned BI = 4;

  logic        clk;
  logic        rst_n;
  logic [6:0]  score_a, score_b;
  logic        upd_valid;
  logic        upd_ready;
  logic        blink_a, blink_b;
  logic [31:0] leds;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  int k    = 0;   // posedges with rst_n high since the last reset edge

  // Scores most recently committed, as the bench expects them on the display
  int com_a = 0, com_b = 0;
  bit com_valid = 0;

  typedef struct {
    int          a;
    int          b;
    logic [31:0] exp;
  } vec_t;

  score_seg_encoder #(.BLINK_INTERVAL(BI)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .score_a   (score_a),
    .score_b   (score_b),
    .upd_valid (upd_valid),
    .upd_ready (upd_ready),
    .blink_a   (blink_a),
    .blink_b   (blink_b),
    .leds      (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  function automatic logic [7:0] code(int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; 9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // Two display bytes {units, tens} for one player's score
  function automatic logic [15:0] player_bytes(int s, bit with_dp);
    logic [7:0] t, u;
    if (s > 99) begin
      t = 8'h40; u = 8'h40;
    end else begin
      t = (s / 10 == 0) ? 8'h00 : code(s / 10);
      u = code(s % 10);
    end
    if (with_dp) u = u | 8'h80;
    return {u, t};
  endfunction

  function automatic logic [31:0] model(int a, int b, bit ba, bit bb, bit hidden);
    logic [15:0] pa, pb;
    pa = (ba && hidden) ? 16'h0000 : player_bytes(a, 1'b1);
    pb = (bb && hidden) ? 16'h0000 : player_bytes(b, 1'b0);
    return {pb, pa};
  endfunction

  function automatic logic [31:0] cur_exp();
    bit hidden;
    hidden = ((k / int'(BI)) % 2) == 1;
    if (!com_valid) return 32'h0;
    return model(com_a, com_b, blink_a, blink_b, hidden);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Full update from IDLE: accept, 8 busy cycles with display held, then commit
  task automatic do_update(input int a, input int b);
    score_a   = 7'(a);
    score_b   = 7'(b);
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    score_a   = 7'($urandom_range(0, 127));
    score_b   = 7'($urandom_range(0, 127));
    for (int i = 0; i < 8; i++) begin
      check("busy_ready", 32'(upd_ready), 32'h0);
      check("busy_hold", leds, cur_exp());
      step();
    end
    com_a = a; com_b = b; com_valid = 1'b1;
    check("done_ready", 32'(upd_ready), 32'h1);
    check("commit_leds", leds, cur_exp());
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!upd_ready && n < 20) begin
      step();
      n++;
    end
    check("ready_wait", 32'(upd_ready), 32'h1);
  endtask

  vec_t tab[6];
  int   prev_a, prev_b, last_cyc;

  initial begin
    tab[0] = '{a: 21,  b: 19,  exp: 32'h6F06_865B};
    tab[1] = '{a: 0,   b: 5,   exp: 32'h6D00_BF00};
    tab[2] = '{a: 120, b: 30,  exp: 32'h3F4F_C040};
    tab[3] = '{a: 99,  b: 100, exp: 32'h4040_EF6F};
    tab[4] = '{a: 10,  b: 7,   exp: 32'h0700_BF06};
    tab[5] = '{a: 127, b: 0,   exp: 32'h3F00_C040};

    rst_n = 1'b0; score_a = '0; score_b = '0; upd_valid = 1'b0;
    blink_a = 1'b0; blink_b = 1'b0;
    step(); step();
    check("reset_leds", leds, 32'h0);
    check("reset_ready", 32'(upd_ready), 32'h1);
    upd_valid = 1'b1;
    step();
    check("reset_hold_ready", 32'(upd_ready), 32'h1);
    upd_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      do_update(tab[i].a, tab[i].b);
      check("table_leds", leds, tab[i].exp);
    end

    // Blink A with interval 4: A bytes alternate, B steady
    do_update(21, 19);
    blink_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      check("blink_low", 32'(leds[15:0]), 32'(cur_exp() & 32'h0000_FFFF));
      check("blink_high", 32'(leds[31:16]), 32'h6F06);
    end
    blink_a = 1'b0;

    // Randomized updates with random blink enables
    for (int i = 0; i < 16; i++) begin
      blink_a = 1'($urandom_range(0, 1));
      blink_b = 1'($urandom_range(0, 1));
      do_update(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      for (int j = 0; j < 5; j++) begin
        step();
        check("rand_leds", leds, cur_exp());
      end
    end
    blink_a = 1'b0; blink_b = 1'b0;

    // Request held during SHIFT is ignored until ready, then accepted
    score_a = 7'd7; score_b = 7'd8; upd_valid = 1'b1;
    step();
    score_a = 7'd3; score_b = 7'd4;
    for (int i = 0; i < 8; i++) begin
      check("held_busy", 32'(upd_ready), 32'h0);
      step();
    end
    com_a = 7; com_b = 8;
    check("held_first", leds, cur_exp());
    check("held_ready", 32'(upd_ready), 32'h1);
    step();
    upd_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("held_busy2", 32'(upd_ready), 32'h0);
      step();
    end
    com_a = 3; com_b = 4;
    check("held_second", leds, cur_exp());

    // Reset mid-SHIFT abandons the conversion
    score_a = 7'd55; score_b = 7'd66; upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    com_valid = 1'b0;
    check("midrst_leds", leds, 32'h0);
    check("midrst_ready", 32'(upd_ready), 32'h1);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("postrst_leds", leds, 32'h0);
      check("postrst_ready", 32'(upd_ready), 32'h1);
    end

    // Back-to-back with upd_valid held: one accept every 9 cycles
    score_a = 7'($urandom_range(0, 127)); score_b = 7'($urandom_range(0, 127));
    upd_valid = 1'b1;
    last_cyc = 0; prev_a = 0; prev_b = 0;
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      if (i > 0) begin
        com_a = prev_a; com_b = prev_b; com_valid = 1'b1;
        check("b2b_leds", leds, cur_exp());
        check("b2b_period", 32'(cyc - last_cyc), 32'd9);
      end
      last_cyc = cyc;
      prev_a = int'(score_a); prev_b = int'(score_b);
      step();
      score_a = 7'($urandom_range(0, 127)); score_b = 7'($urandom_range(0, 127));
    end
    upd_valid = 1'b0;
    wait_ready();
    com_a = prev_a; com_b = prev_b;
    check("b2b_last", leds, cur_exp());

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
